coef_loader: RTL and testbench

Host-side loader/readback engine that sits directly upstream of the dual-channel coefficient RAM, driving its read/write port (addrLrw/addrRrw, datainLrw/datainRrw, weL/weR, dataoutLrw/dataoutRrw).
- Accepts one command per transfer: channel, op, base word address, length.
- Write op: streams 36-bit coefficient words into the selected channel with an auto-incrementing address.
- Readback op: streams words back out for verification.
- Address bits [1:0] select the RAM bank and [13:2] the row, so consecutive addresses interleave across the four banks.

---
 rtl/coef_pkg.sv | 23 ++
 rtl/coef_loader.sv | 154 +++++++++++++++
 tb/tb_coef_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_pkg.sv
// Shared constants, encodings and state type for the coefficient RAM loader.
// The loader drives the read/write port of the dual-channel coefficient RAM.
package coef_pkg;

  localparam int ADDR_W = 14;  // 16k words per channel
  localparam int DATA_W = 36;  // coefficient word width
  localparam int LEN_W  = 15;  // transfer length, 0..16384 words

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;
  localparam logic CHAN_L   = 1'b0;
  localparam logic CHAN_R   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_OUT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/coef_loader.sv
// Host-side write/readback engine for the dual-channel coefficient RAM.
// One command per transfer; addresses auto-increment and wrap at 2^ADDR_W.
module coef_loader
  import coef_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_chan,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] addrLrw,
  output logic [ADDR_W-1:0] addrRrw,
  output logic [DATA_W-1:0] datainLrw,
  output logic [DATA_W-1:0] datainRrw,
  output logic              weL,
  output logic              weR,
  input  logic [DATA_W-1:0] dataoutLrw,
  input  logic [DATA_W-1:0] dataoutRrw
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  words_left;
  logic              chan_q;
  logic              we_l;
  logic              we_r;
  logic [DATA_W-1:0] datain_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              done_q;
  logic              aborted_q;
  logic              wr_hs;
  logic              abort_now;

  // cmd_ready stays low while reset is held, even though the state is IDLE.
  assign cmd_ready = (state == ST_IDLE) && reset;
  assign busy      = (state != ST_IDLE);
  assign wr_ready  = (state == ST_WRITE) && !abort && (words_left != '0);
  assign wr_hs     = wr_valid && wr_ready;
  assign abort_now = abort && (state != ST_IDLE) && (state != ST_FIN);

  assign addrLrw   = addr_q;
  assign addrRrw   = addr_q;
  assign datainLrw = datain_q;
  assign datainRrw = datain_q;
  assign weL       = we_l;
  assign weR       = we_r;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      words_left <= '0;
      chan_q     <= CHAN_L;
      we_l       <= 1'b0;
      we_r       <= 1'b0;
      datain_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      // NOTE: single-cycle strobes default low each cycle and are raised only
      // by the branch that needs them, so no path leaves them stuck high.
      we_l      <= 1'b0;
      we_r      <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      // A word registered last cycle has just been written; step to the next.
      if (we_l || we_r)
        addr_q <= addr_q + ADDR_W'(1);

      if (abort_now) begin
        state      <= ST_IDLE;
        aborted_q  <= 1'b1;
        rd_valid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_valid) begin
              chan_q     <= cmd_chan;
              words_left <= cmd_len;
              addr_q     <= cmd_base;
              if (cmd_len == '0)
                state <= ST_FIN;
              else if (cmd_op == OP_READ)
                state <= ST_RD_ADDR;
              else
                state <= ST_WRITE;
            end
          end

          ST_WRITE: begin
            if (wr_hs) begin
              datain_q   <= wr_data;
              we_l       <= (chan_q == CHAN_L);
              we_r       <= (chan_q == CHAN_R);
              words_left <= words_left - LEN_W'(1);
            end else if (words_left == '0) begin
              state <= ST_FIN;
            end
          end

          // The RAM registers its read and muxes banks on the live address,
          // so the address is held through both RD_ADDR and RD_WAIT.
          ST_RD_ADDR: state <= ST_RD_WAIT;

          ST_RD_WAIT: begin
            rd_data_q  <= (chan_q == CHAN_R) ? dataoutRrw : dataoutLrw;
            rd_valid_q <= 1'b1;
            state      <= ST_RD_OUT;
          end

          ST_RD_OUT: begin
            if (rd_ready) begin
              rd_valid_q <= 1'b0;
              addr_q     <= addr_q + ADDR_W'(1);
              words_left <= words_left - LEN_W'(1);
              state      <= (words_left == LEN_W'(1)) ? ST_FIN : ST_RD_ADDR;
            end
          end

          ST_FIN: begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader with a behavioural dual-channel RAM that has
// a registered read port; write traffic is logged and compared to expectations.
module tb_coef_loader;
  import coef_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic              cmd_chan = 1'b0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              abort = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [ADDR_W-1:0] addrLrw;
  logic [ADDR_W-1:0] addrRrw;
  logic [DATA_W-1:0] datainLrw;
  logic [DATA_W-1:0] datainRrw;
  logic              weL;
  logic              weR;
  logic [DATA_W-1:0] dataoutLrw;
  logic [DATA_W-1:0] dataoutRrw;

  coef_loader dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_chan   (cmd_chan),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .addrLrw    (addrLrw),
    .addrRrw    (addrRrw),
    .datainLrw  (datainLrw),
    .datainRrw  (datainRrw),
    .weL        (weL),
    .weR        (weR),
    .dataoutLrw (dataoutLrw),
    .dataoutRrw (dataoutRrw)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: one registered read per channel, writes on the edge.
  logic [DATA_W-1:0] mem_l [1 << ADDR_W];
  logic [DATA_W-1:0] mem_r [1 << ADDR_W];
  logic [DATA_W-1:0] rq_l = '0;
  logic [DATA_W-1:0] rq_r = '0;

  always @(posedge clock) begin
    if (weL) mem_l[addrLrw] <= datainLrw;
    if (weR) mem_r[addrRrw] <= datainRrw;
    rq_l <= mem_l[addrLrw];
    rq_r <= mem_r[addrRrw];
  end
  assign dataoutLrw = rq_l;
  assign dataoutRrw = rq_r;

  typedef struct {
    int                cyc;
    logic              chan;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ev_t;

  wr_ev_t log_q[$];
  int cyc       = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  int n_checks  = 0;
  int n_errors  = 0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (weL) log_q.push_back('{cyc, CHAN_L, addrLrw, datainLrw});
    if (weR) log_q.push_back('{cyc, CHAN_R, addrRrw, datainRrw});
    if (done) done_cnt = done_cnt + 1;
    if (aborted) abort_cnt = abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic chan,
                          input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    cmd_op    = op;
    cmd_chan  = chan;
    cmd_base  = base;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int g = 0; g < 50 && !cmd_ready; g++) tick();
    check("cmd_ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic chan, input logic [ADDR_W-1:0] base,
                             input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] seed);
    int   i = 0;
    logic hs;
    send_cmd(OP_WRITE, chan, base, len);
    for (int g = 0; g < 200 && i < int'(len); g++) begin
      wr_valid = 1'b1;
      wr_data  = seed + DATA_W'(i);
      hs = wr_ready;
      tick();
      if (hs) i++;
    end
    wr_valid = 1'b0;
    check("wr_words_accepted", i, len);
  endtask

  task automatic read_burst(input logic chan, input logic [ADDR_W-1:0] base,
                            input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] seed,
                            input int stall_idx, input int stall_n, input bit chk_rate);
    int                n = 0;
    int                prev = 0;
    logic [DATA_W-1:0] d0;
    logic [ADDR_W-1:0] a0;
    send_cmd(OP_READ, chan, base, len);
    rd_ready = 1'b1;
    for (int g = 0; g < 400 && n < int'(len); g++) begin
      if (rd_valid) begin
        check("rd_data", rd_data, seed + DATA_W'(n));
        if (chk_rate && n > 0) check("rd_interval", cyc - prev, 3);
        prev = cyc;
        if (n == stall_idx) begin
          d0 = rd_data;
          a0 = chan ? addrRrw : addrLrw;
          rd_ready = 1'b0;
          for (int k = 0; k < stall_n; k++) begin
            tick();
            check("stall_valid", rd_valid, 1);
            check("stall_data", rd_data, d0);
            check("stall_addr", chan ? addrRrw : addrLrw, a0);
          end
          rd_ready = 1'b1;
        end
        n++;
      end
      tick();
    end
    rd_ready = 1'b0;
    check("rd_words_received", n, len);
  endtask

  task automatic wait_done(input int target);
    for (int g = 0; g < 50 && done_cnt < target; g++) tick();
    check("done_count", done_cnt, target);
  endtask

  localparam logic [DATA_W-1:0] SEED_L = 36'h1_0000_0000;
  localparam logic [DATA_W-1:0] SEED_R = 36'hA_5A5A_0000;
  localparam logic [DATA_W-1:0] SEED_A = 36'h3_0000_0040;

  initial begin
    int                dc;
    logic [ADDR_W-1:0] wrap_addr [4];
    wrap_addr = '{14'd16382, 14'd16383, 14'd0, 14'd1};

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_weL", weL, 0);
    check("rst_weR", weR, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_addrL", addrLrw, 0);
    check("rst_datainL", datainLrw, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b1;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    tick();

    // Left write, 8 words streamed back to back
    log_q.delete();
    write_burst(CHAN_L, 14'd0, 15'd8, SEED_L);
    wait_done(1);
    check("wrL_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("wrL_chan", log_q[i].chan, CHAN_L);
      check("wrL_addr", log_q[i].addr, i);
      check("wrL_data", log_q[i].data, SEED_L + DATA_W'(i));
      check("wrL_consecutive", log_q[i].cyc - log_q[0].cyc, i);
    end
    check("wrL_abort_cnt", abort_cnt, 0);

    // Left readback at full rate
    read_burst(CHAN_L, 14'd0, 15'd8, SEED_L, -1, 0, 1'b1);
    wait_done(2);

    // Right write across the address wrap, then read it back
    log_q.delete();
    write_burst(CHAN_R, 14'd16382, 15'd4, SEED_R);
    wait_done(3);
    check("wrR_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check("wrR_chan", log_q[i].chan, CHAN_R);
      check("wrR_addr", log_q[i].addr, wrap_addr[i]);
      check("wrR_data", log_q[i].data, SEED_R + DATA_W'(i));
    end
    read_burst(CHAN_R, 14'd16382, 15'd4, SEED_R, -1, 0, 1'b1);
    wait_done(4);

    // Readback with a 5-cycle consumer stall on word 2
    read_burst(CHAN_L, 14'd0, 15'd4, SEED_L, 2, 5, 1'b0);
    wait_done(5);

    // Abort together with wr_valid on word 3 of a 10-word write
    log_q.delete();
    dc = done_cnt;
    send_cmd(OP_WRITE, CHAN_L, 14'd100, 15'd10);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = SEED_A + DATA_W'(i);
      check("abt_wr_ready_pre", wr_ready, 1);
      tick();
    end
    wr_data = SEED_A + DATA_W'(3);
    abort   = 1'b1;
    #1;
    check("abt_wr_ready_blocked", wr_ready, 0);
    tick();
    abort    = 1'b0;
    wr_valid = 1'b0;
    check("abt_aborted_pulse", aborted, 1);
    check("abt_cmd_ready", cmd_ready, 1);
    check("abt_busy", busy, 0);
    tick();
    check("abt_aborted_once", aborted, 0);
    tick();
    check("abt_abort_cnt", abort_cnt, 1);
    check("abt_no_done", done_cnt, dc);
    check("abt_write_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check("abt_addr", log_q[i].addr, 100 + i);
      check("abt_data", log_q[i].data, SEED_A + DATA_W'(i));
    end

    // Zero-length command: done two cycles after accept, no RAM write
    log_q.delete();
    send_cmd(OP_WRITE, CHAN_L, 14'd5, 15'd0);
    check("len0_done_early", done, 0);
    check("len0_busy", busy, 1);
    tick();
    check("len0_done", done, 1);
    tick();
    check("len0_done_single", done, 0);
    check("len0_no_we", log_q.size(), 0);
    check("len0_done_cnt", done_cnt, dc + 1);

    // Asynchronous reset in the middle of a write
    send_cmd(OP_WRITE, CHAN_L, 14'd200, 15'd4);
    wr_valid = 1'b1;
    wr_data  = SEED_A;
    tick();
    wr_valid = 1'b0;
    check("arst_weL_before", weL, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_weL_dropped", weL, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_wr_ready", wr_ready, 0);
    #3;
    reset = 1'b1;
    tick();
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_addr", addrLrw, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
